ysyx_24090018_ifu: RTL

//  Instruction fetch unit: owns the PC, issues word fetches to instruction memory over a

---
 rtl/ysyx_24090018_ifu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ysyx_24090018_ifu.sv
// Instruction fetch unit: owns the PC, fetches words over a req/resp bus, hands {inst, addr} to IDU.
// Optional misaligned-fetch trap enabled by defining YSYX_24090018_IFU_MISALIGN_CHK_EN.
module ysyx_24090018_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_flag_i,
  input  logic [DATA_WIDTH-1:0] jump_addr_i,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_resp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_resp_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_addr_o,
  output logic                  fetch_err_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  drop_q;
  logic                  drop_nxt;
  logic                  capture;
  logic                  req_hs;
  logic                  req_valid;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] inst_addr_q;
  logic                  mis_cur;
  logic                  mis_nxt;

`ifdef YSYX_24090018_IFU_MISALIGN_CHK_EN
  logic fetch_err_q;
  assign mis_cur     = (pc[1:0] != 2'b00);
  assign mis_nxt     = (pc_nxt[1:0] != 2'b00);
  assign fetch_err_o = fetch_err_q;
`else
  assign mis_cur     = 1'b0;
  assign mis_nxt     = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  assign req_hs           = req_valid & imem_req_ready_i;
  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = pc;
  assign inst_valid_o     = inst_valid;
  assign inst_o           = inst_q;
  assign inst_addr_o      = inst_addr_q;

  // A redirect always wins: it retargets the PC and voids whatever the current state was doing.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop_q;
    capture   = 1'b0;
    if (jump_flag_i) begin
      pc_nxt = jump_addr_i;
    end else begin
      pc_nxt = pc;
    end
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (jump_flag_i) begin
          if (req_hs) begin
            // The old-path request is already in flight; swallow its response.
            state_nxt = S_WAIT;
            drop_nxt  = 1'b1;
          end else begin
            state_nxt = S_REQ;
          end
        end else if (req_hs) begin
          state_nxt = S_WAIT;
        end
`ifdef YSYX_24090018_IFU_MISALIGN_CHK_EN
        else if (mis_cur) begin
          state_nxt = S_ERR;
        end
`endif
        else begin
          state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid_i) begin
          if (jump_flag_i || drop_q) begin
            state_nxt = S_REQ;
            drop_nxt  = 1'b0;
          end else begin
            state_nxt = S_OUT;
            capture   = 1'b1;
          end
        end else if (jump_flag_i) begin
          drop_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_OUT: begin
        if (jump_flag_i) begin
          state_nxt = S_REQ;
        end else if (inst_ready_i) begin
          state_nxt = S_REQ;
          pc_nxt    = pc + PC_STEP;
        end else begin
          state_nxt = S_OUT;
        end
      end
`ifdef YSYX_24090018_IFU_MISALIGN_CHK_EN
      S_ERR: begin
        if (jump_flag_i) begin
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_ERR;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC and outputs; outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      drop_q      <= 1'b0;
      req_valid   <= 1'b0;
      inst_valid  <= 1'b0;
      inst_q      <= '0;
      inst_addr_q <= '0;
`ifdef YSYX_24090018_IFU_MISALIGN_CHK_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drop_q     <= drop_nxt;
      req_valid  <= (state_nxt == S_REQ) && !mis_nxt;
      inst_valid <= (state_nxt == S_OUT);
      if (capture) begin
        inst_q      <= imem_resp_data_i;
        inst_addr_q <= pc;
      end
`ifdef YSYX_24090018_IFU_MISALIGN_CHK_EN
      fetch_err_q <= (state_nxt == S_ERR);
`endif
    end
  end

endmodule
